// File: rtl/riscv_32f_alu_sequencer_pkg.sv
// Shared definitions for the RV32F ALU sequencer: instruction encodings,
// func5 codes, latency classes and sequencer states.
package riscv_32f_alu_sequencer_pkg;

  localparam logic [15:0] ENCODING_NONE   = 16'h0000;
  localparam logic [15:0] ENCODING_FP_OP  = 16'h0200;
  localparam logic [15:0] ENCODING_FLOAD  = 16'h0400;
  localparam logic [15:0] ENCODING_FSTORE = 16'h0800;
  localparam logic [15:0] ENCODING_FMADD  = 16'h1000;
  localparam logic [15:0] ENCODING_FMSUB  = 16'h2000;
  localparam logic [15:0] ENCODING_FNMSUB = 16'h4000;
  localparam logic [15:0] ENCODING_FNMADD = 16'h8000;

  localparam logic [4:0] RV32F_FUNC5_FADD     = 5'b00000;
  localparam logic [4:0] RV32F_FUNC5_FSUB     = 5'b00001;
  localparam logic [4:0] RV32F_FUNC5_FMUL     = 5'b00010;
  localparam logic [4:0] RV32F_FUNC5_FDIV     = 5'b00011;
  localparam logic [4:0] RV32F_FUNC5_FSGNJ    = 5'b00100;
  localparam logic [4:0] RV32F_FUNC5_FMINMAX  = 5'b00101;
  localparam logic [4:0] RV32F_FUNC5_FSQRT    = 5'b01011;
  localparam logic [4:0] RV32F_FUNC5_FCMP     = 5'b10100;
  localparam logic [4:0] RV32F_FUNC5_FCVT_W_S = 5'b11000;
  localparam logic [4:0] RV32F_FUNC5_FCVT_S_W = 5'b11010;
  localparam logic [4:0] RV32F_FUNC5_FMV_X_W  = 5'b11100;
  localparam logic [4:0] RV32F_FUNC5_FMV_W_X  = 5'b11110;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_CMP  = 3'd1,
    CLS_ADD  = 3'd2,
    CLS_MUL  = 3'd3,
    CLS_DIV  = 3'd4,
    CLS_SQRT = 3'd5,
    CLS_CVT  = 3'd6,
    CLS_FMA  = 3'd7
  } op_class_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/riscv_32f_alu_sequencer_op_class_decode.sv
// Combinational decode of the execute-stage FP instruction into the
// latency class of the IP core that will execute it.
module riscv_32F_op_class_decode
  import riscv_32f_alu_sequencer_pkg::*;
(
  input  logic [15:0] encoding_i,
  input  logic [4:0]  func5_i,
  output logic [2:0]  op_class_o
);

  always_comb begin
    op_class_o = CLS_NONE;
    // Encodings without any of the upper bits set never reach an FP core.
    if (encoding_i[15:9] != 7'd0) begin
      case (encoding_i)
        ENCODING_FP_OP: begin
          case (func5_i)
            RV32F_FUNC5_FADD,
            RV32F_FUNC5_FSUB:     op_class_o = CLS_ADD;
            RV32F_FUNC5_FMUL:     op_class_o = CLS_MUL;
            RV32F_FUNC5_FDIV:     op_class_o = CLS_DIV;
            RV32F_FUNC5_FSQRT:    op_class_o = CLS_SQRT;
            RV32F_FUNC5_FMINMAX,
            RV32F_FUNC5_FCMP:     op_class_o = CLS_CMP;
            RV32F_FUNC5_FCVT_W_S,
            RV32F_FUNC5_FCVT_S_W: op_class_o = CLS_CVT;
            default:              op_class_o = CLS_NONE;
          endcase
        end
        ENCODING_FMADD,
        ENCODING_FMSUB,
        ENCODING_FNMSUB,
        ENCODING_FNMADD:          op_class_o = CLS_FMA;
        default:                  op_class_o = CLS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/riscv_32f_alu_sequencer.sv
// Multi-cycle stall/result sequencer for the pipelined RV32F ALU; holds the
// pipeline for the selected core latency and runs FMA as multiply then add.
module riscv_32f_alu_sequencer
  import riscv_32f_alu_sequencer_pkg::*;
#(
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CMP  = 1,
  parameter int LAT_CVT  = 6,
  parameter int CNT_W    = 5
) (
  input  logic        clock_float_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [15:0] encoding_i,
  input  logic [4:0]  func5_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        fma_phase_o,
  output logic        result_en_o,
  output logic        done_o,
  output logic [2:0]  op_class_o
);

  seq_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       class_reg;
  logic             fma_phase_reg;
  logic [2:0]       dec_class;
  logic             accept;
  logic             issue_none;
  logic             mul_last;
  logic             exec_last;

  riscv_32F_op_class_decode u_decode (
    .encoding_i (encoding_i),
    .func5_i    (func5_i),
    .op_class_o (dec_class)
  );

  // Counter load value: core latency minus one, since the load cycle counts.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [2:0] cls);
    case (cls)
      CLS_CMP:  lat_m1 = CNT_W'(LAT_CMP - 1);
      CLS_ADD:  lat_m1 = CNT_W'(LAT_ADD - 1);
      CLS_MUL:  lat_m1 = CNT_W'(LAT_MUL - 1);
      CLS_DIV:  lat_m1 = CNT_W'(LAT_DIV - 1);
      CLS_SQRT: lat_m1 = CNT_W'(LAT_SQRT - 1);
      CLS_CVT:  lat_m1 = CNT_W'(LAT_CVT - 1);
      default:  lat_m1 = '0;
    endcase
  endfunction

  always_comb begin
    accept     = (state_reg == ST_IDLE) && req_i && !flush_i && (dec_class != CLS_NONE);
    issue_none = (state_reg == ST_IDLE) && req_i && !flush_i && (dec_class == CLS_NONE);
    mul_last   = (state_reg == ST_MUL)  && (cnt_reg == '0);
    exec_last  = (state_reg == ST_EXEC) && (cnt_reg == '0);
  end

  // Outputs are forced low while reset is held, even if a request is present.
  assign stall_o     = !reset_i && !flush_i &&
                       (accept || state_reg == ST_MUL || state_reg == ST_EXEC);
  assign done_o      = !reset_i && !flush_i && (issue_none || state_reg == ST_DONE);
  assign result_en_o = !reset_i && !flush_i && exec_last;
  // The adder input switches in the cycle the multiply result becomes valid.
  assign fma_phase_o = !reset_i && (fma_phase_reg || mul_last);
  assign busy_o      = (state_reg != ST_IDLE);
  assign op_class_o  = class_reg;

  always_ff @(posedge clock_float_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      class_reg     <= CLS_NONE;
      fma_phase_reg <= 1'b0;
    end else if (flush_i) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      class_reg     <= CLS_NONE;
      fma_phase_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            class_reg <= dec_class;
            if (dec_class == CLS_FMA) begin
              cnt_reg   <= lat_m1(CLS_MUL);
              state_reg <= ST_MUL;
            end else begin
              cnt_reg   <= lat_m1(dec_class);
              state_reg <= ST_EXEC;
            end
          end
        end
        ST_MUL: begin
          if (cnt_reg == '0) begin
            cnt_reg       <= lat_m1(CLS_ADD);
            state_reg     <= ST_EXEC;
            fma_phase_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_DONE: begin
          // The same instruction is still presented here, so req_i is ignored.
          state_reg     <= ST_IDLE;
          class_reg     <= CLS_NONE;
          fma_phase_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_32f_alu_sequencer.sv
// Self-checking bench: directed scenarios plus random instruction streams
// compared against a cycle-timeline model of each operation.
module tb_riscv_32f_alu_sequencer;
  import riscv_32f_alu_sequencer_pkg::*;

  localparam int LAT_ADD  = 7;
  localparam int LAT_MUL  = 5;
  localparam int LAT_DIV  = 16;
  localparam int LAT_SQRT = 16;
  localparam int LAT_CMP  = 1;
  localparam int LAT_CVT  = 6;
  localparam int NOPS     = 19;

  localparam int OP_FADD   = 0;
  localparam int OP_FDIV   = 3;
  localparam int OP_FSQRT  = 4;
  localparam int OP_FSGNJ  = 5;
  localparam int OP_FMVWX  = 11;
  localparam int OP_FLOAD  = 12;
  localparam int OP_FMADD  = 14;
  localparam int OP_LOWENC = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [15:0] enc;
  logic [4:0]  f5;
  logic        flush;
  logic        stall, busy, fma_phase, result_en, done;
  logic [2:0]  op_class;

  int checks   = 0;
  int failures = 0;

  string       op_name [NOPS];
  logic [15:0] op_enc  [NOPS];
  logic [4:0]  op_f5   [NOPS];
  logic [2:0]  op_cls  [NOPS];

  riscv_32f_alu_sequencer #(
    .LAT_ADD (LAT_ADD), .LAT_MUL (LAT_MUL), .LAT_DIV (LAT_DIV),
    .LAT_SQRT(LAT_SQRT), .LAT_CMP (LAT_CMP), .LAT_CVT (LAT_CVT), .CNT_W(5)
  ) dut (
    .clock_float_i (clk),
    .reset_i       (rst),
    .req_i         (req),
    .encoding_i    (enc),
    .func5_i       (f5),
    .flush_i       (flush),
    .stall_o       (stall),
    .busy_o        (busy),
    .fma_phase_o   (fma_phase),
    .result_en_o   (result_en),
    .done_o        (done),
    .op_class_o    (op_class)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (stall,busy,fma,res,done,cls)", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] cls);
    case (cls)
      CLS_CMP:  return LAT_CMP;
      CLS_ADD:  return LAT_ADD;
      CLS_MUL:  return LAT_MUL;
      CLS_DIV:  return LAT_DIV;
      CLS_SQRT: return LAT_SQRT;
      CLS_CVT:  return LAT_CVT;
      CLS_FMA:  return LAT_MUL + LAT_ADD;
      default:  return 0;
    endcase
  endfunction

  // Expected outputs k cycles after the request is first presented.
  function automatic logic [7:0] expect_at(input logic [2:0] cls, input int k, input logic fl);
    int   lat;
    logic e_stall, e_busy, e_fma, e_res, e_done;
    logic [2:0] e_cls;
    lat = lat_of(cls);
    if (cls == CLS_NONE) begin
      e_stall = 1'b0; e_busy = 1'b0; e_fma = 1'b0; e_res = 1'b0;
      e_done  = !fl;  e_cls  = CLS_NONE;
    end else begin
      e_stall = !fl && (k <= lat);
      e_res   = !fl && (k == lat);
      e_done  = !fl && (k == lat + 1);
      e_busy  = (k >= 1);
      e_fma   = (cls == CLS_FMA) && (k >= LAT_MUL);
      e_cls   = (k >= 1) ? cls : CLS_NONE;
    end
    return {e_stall, e_busy, e_fma, e_res, e_done, e_cls};
  endfunction

  function automatic logic [7:0] observed();
    return {stall, busy, fma_phase, result_en, done, op_class};
  endfunction

  task automatic present(input int idx);
    enc = op_enc[idx];
    f5  = op_f5[idx];
    if (idx == OP_LOWENC) enc = {7'd0, 9'($urandom)};
    if (idx == OP_LOWENC || idx == OP_FLOAD || idx == OP_FLOAD + 1) f5 = 5'($urandom);
  endtask

  // Hold the instruction on the inputs through DONE, optionally flushing at cycle flush_at.
  task automatic run_op(input int idx, input int flush_at);
    logic [2:0] cls;
    int         last;
    cls  = op_cls[idx];
    last = (cls == CLS_NONE) ? 0 : lat_of(cls) + 1;
    req  = 1'b1;
    present(idx);
    for (int k = 0; k <= last; k++) begin
      flush = (k == flush_at);
      @(negedge clk);
      check($sformatf("%s k=%0d", op_name[idx], k), 32'(observed()), 32'(expect_at(cls, k, flush)));
      @(posedge clk);
      #1;
      if (k == flush_at) break;
    end
    req   = 1'b0;
    flush = 1'b0;
    $display("op %-8s cls=%0d lat=%0d flush_at=%0d", op_name[idx], cls, lat_of(cls), flush_at);
  endtask

  task automatic idle_cycles(input int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) begin
      enc = 16'($urandom);
      f5  = 5'($urandom);
      @(negedge clk);
      check("idle", 32'(observed()), 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_mid_fma();
    req = 1'b1;
    present(OP_FMADD);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("FMADD pre-rst k=%0d", k), 32'(observed()), 32'(expect_at(CLS_FMA, k, 1'b0)));
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("rst async", 32'(observed()), 32'h0);
    @(negedge clk);
    check("rst held", 32'(observed()), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    check("rst released", 32'(observed()), 32'h0);
    @(posedge clk);
    #1;
    $display("op FMADD reset asserted at cycle 6");
  endtask

  task automatic setup_ops();
    op_name[0]  = "FADD";    op_enc[0]  = ENCODING_FP_OP;  op_f5[0]  = RV32F_FUNC5_FADD;     op_cls[0]  = CLS_ADD;
    op_name[1]  = "FSUB";    op_enc[1]  = ENCODING_FP_OP;  op_f5[1]  = RV32F_FUNC5_FSUB;     op_cls[1]  = CLS_ADD;
    op_name[2]  = "FMUL";    op_enc[2]  = ENCODING_FP_OP;  op_f5[2]  = RV32F_FUNC5_FMUL;     op_cls[2]  = CLS_MUL;
    op_name[3]  = "FDIV";    op_enc[3]  = ENCODING_FP_OP;  op_f5[3]  = RV32F_FUNC5_FDIV;     op_cls[3]  = CLS_DIV;
    op_name[4]  = "FSQRT";   op_enc[4]  = ENCODING_FP_OP;  op_f5[4]  = RV32F_FUNC5_FSQRT;    op_cls[4]  = CLS_SQRT;
    op_name[5]  = "FSGNJ";   op_enc[5]  = ENCODING_FP_OP;  op_f5[5]  = RV32F_FUNC5_FSGNJ;    op_cls[5]  = CLS_NONE;
    op_name[6]  = "FMINMAX"; op_enc[6]  = ENCODING_FP_OP;  op_f5[6]  = RV32F_FUNC5_FMINMAX;  op_cls[6]  = CLS_CMP;
    op_name[7]  = "FCMP";    op_enc[7]  = ENCODING_FP_OP;  op_f5[7]  = RV32F_FUNC5_FCMP;     op_cls[7]  = CLS_CMP;
    op_name[8]  = "FCVTWS";  op_enc[8]  = ENCODING_FP_OP;  op_f5[8]  = RV32F_FUNC5_FCVT_W_S; op_cls[8]  = CLS_CVT;
    op_name[9]  = "FCVTSW";  op_enc[9]  = ENCODING_FP_OP;  op_f5[9]  = RV32F_FUNC5_FCVT_S_W; op_cls[9]  = CLS_CVT;
    op_name[10] = "FMVXW";   op_enc[10] = ENCODING_FP_OP;  op_f5[10] = RV32F_FUNC5_FMV_X_W;  op_cls[10] = CLS_NONE;
    op_name[11] = "FMVWX";   op_enc[11] = ENCODING_FP_OP;  op_f5[11] = RV32F_FUNC5_FMV_W_X;  op_cls[11] = CLS_NONE;
    op_name[12] = "FLOAD";   op_enc[12] = ENCODING_FLOAD;  op_f5[12] = 5'd0;                 op_cls[12] = CLS_NONE;
    op_name[13] = "FSTORE";  op_enc[13] = ENCODING_FSTORE; op_f5[13] = 5'd0;                 op_cls[13] = CLS_NONE;
    op_name[14] = "FMADD";   op_enc[14] = ENCODING_FMADD;  op_f5[14] = 5'd0;                 op_cls[14] = CLS_FMA;
    op_name[15] = "FMSUB";   op_enc[15] = ENCODING_FMSUB;  op_f5[15] = 5'd0;                 op_cls[15] = CLS_FMA;
    op_name[16] = "FNMSUB";  op_enc[16] = ENCODING_FNMSUB; op_f5[16] = 5'd0;                 op_cls[16] = CLS_FMA;
    op_name[17] = "FNMADD";  op_enc[17] = ENCODING_FNMADD; op_f5[17] = 5'd0;                 op_cls[17] = CLS_FMA;
    op_name[18] = "LOWENC";  op_enc[18] = ENCODING_NONE;   op_f5[18] = 5'd0;                 op_cls[18] = CLS_NONE;
  endtask

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int idx, last, fl;
    setup_ops();
    rst = 1'b1; req = 1'b0; enc = '0; f5 = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset state", 32'(observed()), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(2);

    run_op(OP_FADD, -1);
    run_op(OP_FMADD, -1);
    run_op(OP_FSGNJ, -1);
    run_op(OP_FMVWX, -1);
    run_op(OP_FLOAD, -1);
    run_op(OP_FDIV, -1);
    run_op(OP_FSQRT, 4);
    idle_cycles(1);
    reset_mid_fma();
    run_op(OP_FADD, -1);

    for (int n = 0; n < 80; n++) begin
      idx  = $urandom_range(0, NOPS - 1);
      last = (op_cls[idx] == CLS_NONE) ? 0 : lat_of(op_cls[idx]) + 1;
      fl   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, last) : -1;
      run_op(idx, fl);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
